// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: instruction formats, loader states and field widths.
package mips_pkg;

   localparam int OP_W     = 6;
   localparam int REG_W    = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int TARGET_W = 26;
   localparam int INSTR_W  = 32;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_END = 2'd3
   } instr_fmt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } loader_state_t;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: selects the fields relevant to the format and builds the 32-bit MIPS word.
module instr_packer
   import mips_pkg::*;
(
   input  instr_fmt_t            fmt,
   input  logic [OP_W-1:0]       op,
   input  logic [REG_W-1:0]      rs,
   input  logic [REG_W-1:0]      rt,
   input  logic [REG_W-1:0]      rd,
   input  logic [REG_W-1:0]      shamt,
   input  logic [FUNCT_W-1:0]    funct,
   input  logic [IMM_W-1:0]      imm,
   input  logic [TARGET_W-1:0]   target,
   output logic [INSTR_W-1:0]    word
);

   always_comb begin
      word = '0;
      case (fmt)
         FMT_R:   word = {op, rs, rt, rd, shamt, funct};
         FMT_I:   word = {op, rs, rt, imm};
         FMT_J:   word = {op, target};
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/imem_writer.sv
// Program loader: accepts field tuples, writes encoded words to consecutive addresses from 0,
// and keeps the core in reset until the program is complete.
module imem_writer
   import mips_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [1:0]           fmt_i2,
   input  logic [5:0]           op_i6,
   input  logic [4:0]           rs_i5,
   input  logic [4:0]           rt_i5,
   input  logic [4:0]           rd_i5,
   input  logic [4:0]           shamt_i5,
   input  logic [5:0]           funct_i6,
   input  logic [15:0]          imm_i16,
   input  logic [25:0]          target_i26,
   output logic                 wmem_en_o,
   output logic [ADDR_W-1:0]    wmem_addr_o,
   output logic [31:0]          wmem_data_o32,
   output logic [ADDR_W:0]      count_o,
   output logic                 cpu_reset_o,
   output logic                 done_o,
   output logic                 full_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

   loader_state_t          state_reg;
   logic                   ready_reg;
   logic                   wmem_en_reg;
   logic [ADDR_W-1:0]      wmem_addr_reg;
   logic [31:0]            wmem_data_reg;
   logic [ADDR_W:0]        count_reg;
   logic                   cpu_reset_reg;
   logic                   done_reg;
   logic                   full_reg;
   logic [31:0]            packed_word;
   instr_fmt_t             fmt;

   assign fmt = instr_fmt_t'(fmt_i2);

   instr_packer u_packer (
      .fmt    (fmt),
      .op     (op_i6),
      .rs     (rs_i5),
      .rt     (rt_i5),
      .rd     (rd_i5),
      .shamt  (shamt_i5),
      .funct  (funct_i6),
      .imm    (imm_i16),
      .target (target_i26),
      .word   (packed_word)
   );

   // count_reg tracks accepted words; the write address of a word is the count before it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg     <= ST_IDLE;
         ready_reg     <= 1'b0;
         wmem_en_reg   <= 1'b0;
         wmem_addr_reg <= '0;
         wmem_data_reg <= '0;
         count_reg     <= '0;
         cpu_reset_reg <= 1'b1;
         done_reg      <= 1'b0;
         full_reg      <= 1'b0;
      end else begin
         wmem_en_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state_reg     <= ST_LOAD;
                  ready_reg     <= 1'b1;
                  count_reg     <= '0;
                  cpu_reset_reg <= 1'b1;
                  done_reg      <= 1'b0;
                  full_reg      <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (valid_i && ready_reg) begin
                  if (fmt == FMT_END) begin
                     state_reg     <= ST_DONE;
                     ready_reg     <= 1'b0;
                     done_reg      <= 1'b1;
                     cpu_reset_reg <= 1'b0;
                  end else begin
                     wmem_en_reg   <= 1'b1;
                     wmem_addr_reg <= count_reg[ADDR_W-1:0];
                     wmem_data_reg <= packed_word;
                     count_reg     <= count_reg + 1'b1;
                     if (count_reg == LAST_IDX) begin
                        state_reg     <= ST_DONE;
                        ready_reg     <= 1'b0;
                        done_reg      <= 1'b1;
                        full_reg      <= 1'b1;
                        cpu_reset_reg <= 1'b0;
                     end
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign ready_o       = ready_reg;
   assign wmem_en_o     = wmem_en_reg;
   assign wmem_addr_o   = wmem_addr_reg;
   assign wmem_data_o32 = wmem_data_reg;
   assign count_o       = count_reg;
   assign cpu_reset_o   = cpu_reset_reg;
   assign done_o        = done_reg;
   assign full_o        = full_reg;

endmodule

// File: tb/tb_imem_writer.sv
// Randomized bench for imem_writer: a behavioural loader model predicts every output each cycle.
module tb_imem_writer;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        start_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [1:0]  fmt_i2 = 2'd0;
   logic [5:0]  op_i6 = '0;
   logic [4:0]  rs_i5 = '0, rt_i5 = '0, rd_i5 = '0, shamt_i5 = '0;
   logic [5:0]  funct_i6 = '0;
   logic [15:0] imm_i16 = '0;
   logic [25:0] target_i26 = '0;
   logic        wmem_en_o;
   logic [5:0]  wmem_addr_o;
   logic [31:0] wmem_data_o32;
   logic [6:0]  count_o;
   logic        cpu_reset_o, done_o, full_o;

   imem_writer #(.ADDR_W(ADDR_W)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .valid_i(valid_i),
      .ready_o(ready_o), .fmt_i2(fmt_i2), .op_i6(op_i6), .rs_i5(rs_i5),
      .rt_i5(rt_i5), .rd_i5(rd_i5), .shamt_i5(shamt_i5), .funct_i6(funct_i6),
      .imm_i16(imm_i16), .target_i26(target_i26), .wmem_en_o(wmem_en_o),
      .wmem_addr_o(wmem_addr_o), .wmem_data_o32(wmem_data_o32), .count_o(count_o),
      .cpu_reset_o(cpu_reset_o), .done_o(done_o), .full_o(full_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Encoding by field weights, straight from the bit positions of each format.
   function automatic logic [31:0] encode(input int fmt, input int op, input int rs, input int rt,
                                          input int rd, input int sh, input int fn,
                                          input int imm, input int tgt);
      longint w;
      case (fmt)
         0: w = op * 64'd67108864 + rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
         1: w = op * 64'd67108864 + rs * 2097152 + rt * 65536 + imm;
         2: w = op * 64'd67108864 + tgt;
         default: w = 0;
      endcase
      return w[31:0];
   endfunction

   // Model: loading flag, number of words placed, and the outputs the spec demands.
   bit        m_loading = 0;
   int        m_words = 0;
   bit        m_done = 0, m_full = 0, m_cpu_rst = 1, m_en = 0;
   int        m_addr = 0;
   logic [31:0] m_data = 0;

   always @(posedge clk_i) begin
      m_en = 0;
      if (reset_i) begin
         m_loading = 0; m_words = 0; m_done = 0; m_full = 0; m_cpu_rst = 1;
         m_addr = 0; m_data = 0;
      end else if (!m_loading) begin
         if (start_i) begin
            m_loading = 1; m_words = 0; m_done = 0; m_full = 0; m_cpu_rst = 1;
         end
      end else if (valid_i) begin
         if (fmt_i2 == 2'd3) begin
            m_loading = 0; m_done = 1; m_cpu_rst = 0;
         end else begin
            m_en = 1;
            m_addr = m_words;
            m_data = encode(fmt_i2, op_i6, rs_i5, rt_i5, rd_i5, shamt_i5, funct_i6,
                            imm_i16, target_i26);
            m_words++;
            if (m_words == DEPTH) begin
               m_loading = 0; m_done = 1; m_full = 1; m_cpu_rst = 0;
            end
         end
      end
   end

   logic [31:0] dut_mem [DEPTH];
   int wr_count = 0;

   always @(negedge clk_i) begin
      chk("ready_o", 32'(ready_o), 32'(m_loading));
      chk("wmem_en_o", 32'(wmem_en_o), 32'(m_en));
      chk("wmem_addr_o", 32'(wmem_addr_o), 32'(m_addr));
      chk("wmem_data_o32", wmem_data_o32, m_data);
      chk("count_o", 32'(count_o), 32'(m_words));
      chk("cpu_reset_o", 32'(cpu_reset_o), 32'(m_cpu_rst));
      chk("done_o", 32'(done_o), 32'(m_done));
      chk("full_o", 32'(full_o), 32'(m_full));
      if (wmem_en_o) begin
         dut_mem[wmem_addr_o] = wmem_data_o32;
         wr_count++;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic garbage();
      op_i6 = 6'($urandom); rs_i5 = 5'($urandom); rt_i5 = 5'($urandom);
      rd_i5 = 5'($urandom); shamt_i5 = 5'($urandom); funct_i6 = 6'($urandom);
      imm_i16 = 16'($urandom); target_i26 = 26'($urandom);
   endtask

   task automatic do_start();
      start_i = 1; tick(); start_i = 0;
      wr_count = 0;
   endtask

   task automatic send(input int fmt);
      fmt_i2 = 2'(fmt); valid_i = 1; tick(); valid_i = 0; garbage();
   endtask

   initial begin
      garbage();
      tick(); tick();
      reset_i = 0;
      chk("reset cpu_reset_o", 32'(cpu_reset_o), 32'd1);
      chk("reset ready_o", 32'(ready_o), 32'd0);
      // valid outside LOAD must be ignored
      valid_i = 1; fmt_i2 = 2'd0; tick(); valid_i = 0;

      // add $3,$1,$2 then END
      do_start();
      chk("ready after start", 32'(ready_o), 32'd1);
      garbage(); op_i6 = 6'h00; rs_i5 = 5'd1; rt_i5 = 5'd2; rd_i5 = 5'd3;
      shamt_i5 = 5'd0; funct_i6 = 6'h20;
      send(0);
      send(3);
      chk("add word", dut_mem[0], 32'h00221820);
      chk("add done", 32'(done_o), 32'd1);
      chk("add count", 32'(count_o), 32'd1);
      chk("add writes", 32'(wr_count), 32'd1);

      // lw $2,4($0) and j 0x10 back to back, garbage elsewhere
      do_start();
      garbage(); op_i6 = 6'h23; rs_i5 = 5'd0; rt_i5 = 5'd2; imm_i16 = 16'h0004;
      fmt_i2 = 2'd1; valid_i = 1; tick();
      chk("lw write", wmem_data_o32, 32'h8C020004);
      garbage(); op_i6 = 6'h02; target_i26 = 26'h10; fmt_i2 = 2'd2; tick();
      chk("j write", wmem_data_o32, 32'h08000010);
      chk("j addr", 32'(wmem_addr_o), 32'd1);
      valid_i = 0;
      send(3);
      chk("lw/j writes", 32'(wr_count), 32'd2);

      // random valid gaps, then END
      do_start();
      for (int i = 0; i < 40; i++) begin
         garbage();
         fmt_i2 = 2'($urandom_range(0, 2));
         valid_i = $urandom_range(0, 1) == 1;
         tick();
      end
      valid_i = 0;
      send(3);
      chk("random writes vs count", 32'(wr_count), 32'(count_o));

      // fill to DEPTH without END
      do_start();
      for (int i = 0; i < DEPTH + 6; i++) begin
         garbage();
         fmt_i2 = 2'($urandom_range(0, 2));
         valid_i = 1;
         tick();
      end
      valid_i = 0;
      chk("full writes", 32'(wr_count), 32'd64);
      chk("full full_o", 32'(full_o), 32'd1);
      chk("full ready_o", 32'(ready_o), 32'd0);
      chk("full count_o", 32'(count_o), 32'd64);

      // restart from DONE, reload one word
      do_start();
      chk("restart count", 32'(count_o), 32'd0);
      chk("restart cpu_reset", 32'(cpu_reset_o), 32'd1);
      chk("restart full", 32'(full_o), 32'd0);
      send(1);
      chk("reload addr", 32'(wmem_addr_o), 32'd0);

      // reset right after an accept, with start held alongside
      send(0);
      reset_i = 1; start_i = 1; tick();
      chk("reset drops write", 32'(wmem_en_o), 32'd0);
      chk("reset cpu_reset", 32'(cpu_reset_o), 32'd1);
      tick();
      reset_i = 0; start_i = 0; tick();
      chk("start under reset ignored", 32'(ready_o), 32'd0);

      // empty program
      do_start();
      send(3);
      chk("empty done", 32'(done_o), 32'd1);
      chk("empty count", 32'(count_o), 32'd0);
      chk("empty writes", 32'(wr_count), 32'd0);
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/imem_writer.md
# imem_writer

Sequential instruction encoder and loader: accepts instruction field tuples over a valid/ready stream, packs each into a 32-bit MIPS R/I/J word, and writes the words to consecutive instruction-memory addresses from 0. It holds the single-cycle core in reset until the program is fully written, then releases it. It sits between the host/test loader and the instruction memory that feeds the core's op/funct decode path.

## Interface
- ADDR_W, 6, instruction-memory word-address width; DEPTH = 2**ADDR_W words
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  reset, synchronous, active-high
- start_i  in  1  pulse that begins a load; honoured in IDLE and DONE, ignored in LOAD
- valid_i  in  1  field tuple valid
- ready_o  out  1  tuple accepted when valid_i & ready_o
- fmt_i2  in  2  0=R, 1=I, 2=J, 3=END (terminator, no word written)
- op_i6  in  6  opcode field
- rs_i5, rt_i5, rd_i5, shamt_i5  in  5 each  register/shift fields
- funct_i6  in  6  function field (R only)
- imm_i16  in  16  immediate (I only)
- target_i26  in  26  jump target (J only)
- wmem_en_o  out  1  instruction-memory write strobe
- wmem_addr_o  out  ADDR_W  word address
- wmem_data_o32  out  32  encoded instruction
- count_o  out  ADDR_W+1  words written in current load
- cpu_reset_o  out  1  core reset, high except in DONE
- done_o  out  1  load complete
- full_o  out  1  load ended by reaching DEPTH words, not by END

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: ready_o=0, cpu_reset_o=1; start_i → LOAD, count cleared.
- LOAD: ready_o=1 while accepted words < DEPTH; other fields ignored per format.
- Encoding: R = {op, rs, rt, rd, shamt, funct}; I = {op, rs, rt, imm}; J = {op, target}. Unused fields are don't-care and must not leak into the word.
- Accepting a R/I/J tuple registers the word; the write is issued next cycle at address = count; count increments with the write.
- Accepting END → DONE; no write.
- Accepting the DEPTH-th word → DONE with full_o=1; ready_o low from then on.
- DONE: done_o=1, cpu_reset_o=0, ready_o=0; start_i → LOAD, count cleared, cpu_reset_o=1 again, full_o cleared.
- start_i in LOAD ignored; valid_i outside LOAD ignored.

## Timing
- Reset values: state IDLE, ready_o=0, wmem_en_o=0, wmem_addr_o=0, wmem_data_o32=0, count_o=0, cpu_reset_o=1, done_o=0, full_o=0.
- start_i at cycle t → ready_o=1 at t+1.
- Accept at t → wmem_en_o=1 at t+1 with that word; back-to-back accepts give one write per cycle, no bubbles.
- END accepted at t → done_o=1, cpu_reset_o=0 at t+1. Any word accepted at t-1 is written at t, so memory is complete before the core is released.
- DEPTH-th word accepted at t → ready_o=0, write, done_o=1, full_o=1 all at t+1.
- wmem_en_o is a single-cycle strobe per word; wmem_addr_o/data_o32 hold their last values when idle.
- reset_i wins over start_i and valid_i in the same cycle. Reset mid-load drops the pending write (wmem_en_o=0 next cycle) and returns to reset values.
- Empty program (END first): DONE with count_o=0, no writes.

## Structure
- Shared package mips_pkg: instr_fmt_t enum (FMT_R, FMT_I, FMT_J, FMT_END), loader_state_t enum, field-width constants (OP_W=6, REG_W=5, FUNCT_W=6, IMM_W=16, TARGET_W=26).
- Sub-module instr_packer: purely combinational fmt+fields → 32-bit word, reusable by the decode-side testbenches.
- imem_writer holds the FSM, count/address register, and registered write stage.

## Test plan
- Load add $3,$1,$2 (R, op 0x00, rs 1, rt 2, rd 3, shamt 0, funct 0x20), then END → write 0x00221820 at addr 0; done_o one cycle after END accept; count_o=1.
- Back-to-back lw $2,4($0) (I, op 0x23, rt 2, imm 0x0004) and j 0x10 (J, op 0x02) → writes 0x8C020004 @0 and 0x08000010 @1 on consecutive cycles; garbage in unused fields does not change the words.
- valid_i toggled randomly, then END → addresses contiguous and no duplicate or missing writes; cpu_reset_o high until done_o.
- DEPTH=64 words with no END → 64 writes to addrs 0..63, full_o=1, done_o=1, ready_o=0; a 65th valid_i is never accepted.
- reset_i the cycle after an accept → no write next cycle, all outputs at reset values, cpu_reset_o=1; start_i held together with reset_i is ignored.
- start_i in DONE → count_o=0, cpu_reset_o=1; reload of one word writes addr 0.
